ntt_sdf_unloader: RTL and testbench

- Sits at the output of the SDF NTT/INTT pipeline and consumes its streamed result: a one-cycle `finish` pulse followed by one coefficient per cycle for N = 2^LOGN cycles.
- Reorders the frame into natural order and presents it to the host/DMA side over a valid/ready stream with a last marker.
- The forward NTT stream arrives bit-reversed and is reordered; the INTT stream arrives natural and passes through in order.
- A ping-pong buffer lets the pipeline deliver a new frame while the previous one drains.

---
 rtl/ntt_sdf_unloader_pkg.sv | 23 ++
 rtl/ntt_unload_bank.sv | 33 +++
 rtl/ntt_sdf_unloader.sv | 222 ++++++++++++++++++++++
 tb/tb_ntt_sdf_unloader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_sdf_unloader_pkg.sv
// Shared definitions for the SDF NTT unloader: bank-state encoding, sizing and
// the bit-reversal helper used to place forward-NTT words.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_CAPT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } bank_st_e;

  localparam int unsigned NBANK = 2;
  // Output-side storage: head register plus two skid/prefetch entries.
  localparam int unsigned SLOTS = 3;

  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned logn);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < logn; i++) r[logn-1-i] = x[i];
    return r;
  endfunction

endpackage

// File: rtl/ntt_unload_bank.sv
// One ping-pong bank: simple dual-port N x LOGQ RAM with a registered read
// followed by DELAY_BRAM-1 extra output stages.
module ntt_unload_bank #(
  parameter int unsigned LOGQ       = 16,
  parameter int unsigned LOGN       = 3,
  parameter int unsigned DELAY_BRAM = 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [LOGN-1:0] waddr,
  input  logic [LOGQ-1:0] wdata,
  input  logic            re,
  input  logic [LOGN-1:0] raddr,
  output logic [LOGQ-1:0] rdata
);

  localparam int unsigned N = 1 << LOGN;

  logic [LOGQ-1:0] mem  [N];
  logic [LOGQ-1:0] rd_q [DELAY_BRAM];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rd_q[0] <= mem[raddr];
    for (int i = 1; i < int'(DELAY_BRAM); i++) rd_q[i] <= rd_q[i-1];
  end

  assign rdata = rd_q[DELAY_BRAM-1];

endmodule

// File: rtl/ntt_sdf_unloader.sv
// Captures SDF NTT/INTT output frames into a ping-pong buffer and drains them
// in natural order over a valid/ready stream with a last marker.
module ntt_sdf_unloader
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ       = 16,
  parameter int unsigned LOGN       = 3,
  parameter int unsigned DELAY_BRAM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            finish,
  input  logic            intt,
  input  logic [LOGQ-1:0] ntt_out,
  output logic [LOGQ-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            drop
);

  localparam int unsigned N = 1 << LOGN;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  bank_st_e        st [NBANK];
  bank_st_e        st_n [NBANK];
  logic            wb, wb_n, rb, rb_n, ib, ib_n;
  logic            cap_act, cap_act_n, cap_disc, cap_disc_n, cap_intt, cap_intt_n;
  logic [LOGN-1:0] cap_cnt, cap_cnt_n;
  logic            iss_busy, iss_busy_n;
  logic [LOGN-1:0] rd_addr, rd_addr_n;
  logic [LOGQ-1:0] q_data [SLOTS];
  logic [LOGQ-1:0] qd_n [SLOTS];
  logic            q_last [SLOTS];
  logic            ql_n [SLOTS];
  logic [1:0]      cnt, cnt_n;
  logic            valid_q, busy_q, drop_q, drop_n;

  logic [DELAY_BRAM-1:0] p_valid, p_last, p_sel;
  logic [2:0]      infl;

  logic            wr, re, free_wb, cap_done, can_start, credit, pop, pop_last, push, mode;
  logic [LOGN-1:0] waddr, raddr, c;
  logic [LOGQ-1:0] rdata;
  logic [LOGQ-1:0] rdata_b [NBANK];

  for (genvar b = 0; b < int'(NBANK); b++) begin : g_bank
    ntt_unload_bank #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(DELAY_BRAM)) u_bank (
      .clk   (clk),
      .we    (wr && (wb == 1'(b))),
      .waddr (waddr),
      .wdata (ntt_out),
      .re    (re && (ib == 1'(b))),
      .raddr (raddr),
      .rdata (rdata_b[b])
    );
  end

  assign rdata = rdata_b[p_sel[DELAY_BRAM-1]];
  assign push  = p_valid[DELAY_BRAM-1];

  always_comb begin
    infl = '0;
    for (int i = 0; i < int'(DELAY_BRAM); i++) infl = infl + 3'(p_valid[i]);
  end

  always_comb begin
    st_n       = st;
    wb_n       = wb;
    rb_n       = rb;
    ib_n       = ib;
    cap_act_n  = cap_act;
    cap_disc_n = cap_disc;
    cap_intt_n = cap_intt;
    cap_cnt_n  = cap_cnt;
    iss_busy_n = iss_busy;
    rd_addr_n  = rd_addr;
    drop_n     = drop_q;
    qd_n       = q_data;
    ql_n       = q_last;
    cnt_n      = cnt;

    pop      = valid_q && m_ready;
    pop_last = pop && q_last[0];

    // A bank whose last word is handed off this cycle is free for a new frame.
    free_wb = (st[wb] == ST_EMPTY) || ((st[wb] == ST_DRAIN) && pop_last && (rb == wb));

    if (pop_last) begin
      st_n[rb] = ST_EMPTY;
      rb_n     = ~rb;
    end

    c     = cap_act ? cap_cnt : '0;
    mode  = cap_act ? cap_intt : intt;
    wr    = (!cap_act && finish && free_wb) || (cap_act && !cap_disc);
    waddr = mode ? c : LOGN'(bitrev(32'(c), LOGN));

    if (finish && (cap_act || !free_wb)) drop_n = 1'b1;

    if (!cap_act && finish) begin
      cap_act_n  = 1'b1;
      cap_disc_n = !free_wb;
      cap_intt_n = intt;
      cap_cnt_n  = LOGN'(1);
      if (free_wb) st_n[wb] = ST_CAPT;
    end

    cap_done = cap_act && !cap_disc && (cap_cnt == LAST);
    if (cap_act) begin
      cap_cnt_n = cap_cnt + LOGN'(1);
      if (cap_cnt == LAST) begin
        cap_act_n = 1'b0;
        if (!cap_disc) begin
          st_n[wb] = ST_FULL;
          wb_n     = ~wb;
        end
      end
    end

    // Address 0 is always written at c=0, so reading may begin on the last
    // capture cycle; every later address is written before it is read.
    credit    = (3'(cnt) + infl) < (3'(SLOTS) + 3'(pop));
    can_start = !iss_busy && ((st[ib] == ST_FULL) || (cap_done && (wb == ib)));
    re        = credit && (iss_busy || can_start);
    raddr     = iss_busy ? rd_addr : '0;

    if (re) begin
      if (!iss_busy) begin
        iss_busy_n = 1'b1;
        st_n[ib]   = ST_DRAIN;
      end
      rd_addr_n = raddr + LOGN'(1);
      if (raddr == LAST) begin
        iss_busy_n = 1'b0;
        ib_n       = ~ib;
      end
    end

    if (pop) begin
      for (int i = 0; i < int'(SLOTS) - 1; i++) begin
        qd_n[i] = q_data[i+1];
        ql_n[i] = q_last[i+1];
      end
      ql_n[SLOTS-1] = 1'b0;
      cnt_n = cnt - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (2'(i) == cnt_n) begin
          qd_n[i] = rdata;
          ql_n[i] = p_last[DELAY_BRAM-1];
        end
      end
      cnt_n = cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= '{default: ST_EMPTY};
      wb       <= 1'b0;
      rb       <= 1'b0;
      ib       <= 1'b0;
      cap_act  <= 1'b0;
      cap_disc <= 1'b0;
      cap_intt <= 1'b0;
      cap_cnt  <= '0;
      iss_busy <= 1'b0;
      rd_addr  <= '0;
      q_data   <= '{default: '0};
      q_last   <= '{default: 1'b0};
      cnt      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      st       <= st_n;
      wb       <= wb_n;
      rb       <= rb_n;
      ib       <= ib_n;
      cap_act  <= cap_act_n;
      cap_disc <= cap_disc_n;
      cap_intt <= cap_intt_n;
      cap_cnt  <= cap_cnt_n;
      iss_busy <= iss_busy_n;
      rd_addr  <= rd_addr_n;
      q_data   <= qd_n;
      q_last   <= ql_n;
      cnt      <= cnt_n;
      valid_q  <= (cnt_n != 2'd0);
      busy_q   <= (st_n[0] != ST_EMPTY) || (st_n[1] != ST_EMPTY) || (cnt_n != 2'd0);
      drop_q   <= drop_n;
    end
  end

  // Read-side bookkeeping travelling alongside the RAM latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_valid <= '0;
      p_last  <= '0;
      p_sel   <= '0;
    end else begin
      for (int i = int'(DELAY_BRAM) - 1; i > 0; i--) begin
        p_valid[i] <= p_valid[i-1];
        p_last[i]  <= p_last[i-1];
        p_sel[i]   <= p_sel[i-1];
      end
      p_valid[0] <= re;
      p_last[0]  <= (raddr == LAST);
      p_sel[0]   <= ib;
    end
  end

  assign m_data  = q_data[0];
  assign m_last  = q_last[0];
  assign m_valid = valid_q;
  assign busy    = busy_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_ntt_sdf_unloader.sv
// Directed bench for ntt_sdf_unloader with LOGQ=16, LOGN=3, DELAY_BRAM=1.
module tb_ntt_sdf_unloader;

  logic        clk, rst, finish, intt, m_ready;
  logic [15:0] ntt_out, m_data;
  logic        m_valid, m_last, busy, drop;

  ntt_sdf_unloader #(.LOGQ(16), .LOGN(3), .DELAY_BRAM(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .finish  (finish),
    .intt    (intt),
    .ntt_out (ntt_out),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] frm [8];
  int          br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          gen_idx = 0;
  int          gen_left = 0;
  logic [15:0] rec_data [$];
  logic        rec_last [$];
  int          rec_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record the handshake of the cycle ending now, advance one cycle, drive inputs.
  task automatic step();
    if (m_valid && m_ready) begin
      rec_data.push_back(m_data);
      rec_last.push_back(m_last);
      rec_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    finish = 1'b0;
    if (gen_left > 0) begin
      ntt_out = frm[gen_idx];
      gen_idx++;
      gen_left--;
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  // Frame carrying base+k for natural index k, in the order the pipeline emits it.
  task automatic start_frame(input logic md, input int base);
    for (int k = 0; k < 8; k++) frm[k] = 16'(base + (md ? k : br[k]));
    finish   = 1'b1;
    intt     = md;
    ntt_out  = frm[0];
    gen_idx  = 1;
    gen_left = 7;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    finish   = 1'b0;
    gen_left = 0;
    step();
    step();
    rst = 1'b1;
    cyc = 0;
    rec_data.delete();
    rec_last.delete();
    rec_cyc.delete();
  endtask

  task automatic check_stream(input string tag, input int n, input int base, input int first);
    check({tag, "_count"}, 32'(rec_data.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < rec_data.size()) begin
        check({tag, "_data"}, 32'(rec_data[k]), 32'(base + k));
        check({tag, "_last"}, 32'(rec_last[k]), 32'((k % 8) == 7));
        if (first >= 0) check({tag, "_cycle"}, 32'(rec_cyc[k]), 32'(first + k));
      end else begin
        check({tag, "_missing"}, 32'(k), 32'(rec_data.size()));
      end
    end
  endtask

  initial begin
    rst = 1'b0; finish = 1'b0; intt = 1'b0; ntt_out = '0; m_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);

    // Forward frame, bit-reversed stream
    step_to(10); start_frame(1'b0, 0);
    step_to(11);
    check("fwd_busy", 32'(busy), 1);
    step_to(18);
    check("fwd_not_early", 32'(m_valid), 0);
    step_to(30);
    check_stream("fwd", 8, 0, 19);
    check("fwd_drop", 32'(drop), 0);
    check("fwd_idle", 32'(busy), 0);

    // INTT frame, natural stream
    do_reset();
    step_to(10); start_frame(1'b1, 10);
    step_to(30);
    check_stream("intt", 8, 10, 19);
    check("intt_drop", 32'(drop), 0);

    // Back-to-back frames, mixed modes
    do_reset();
    step_to(10); start_frame(1'b0, 0);
    step_to(18); start_frame(1'b1, 8);
    step_to(26); start_frame(1'b0, 16);
    step_to(42);
    check("b2b_busy_last", 32'(busy), 1);
    step_to(43);
    check("b2b_busy_fall", 32'(busy), 0);
    step_to(50);
    check_stream("b2b", 24, 0, 19);
    check("b2b_drop", 32'(drop), 0);

    // Backpressure and overflow
    do_reset();
    m_ready = 1'b0;
    step_to(10); start_frame(1'b1, 0);
    step_to(18); start_frame(1'b1, 8);
    step_to(20);
    check("stall_valid_a", 32'(m_valid), 1);
    check("stall_data_a", 32'(m_data), 0);
    step_to(26);
    check("ovf_drop_before", 32'(drop), 0);
    start_frame(1'b1, 100);
    step_to(27);
    check("ovf_drop", 32'(drop), 1);
    step_to(40);
    check("stall_valid_b", 32'(m_valid), 1);
    check("stall_data_b", 32'(m_data), 0);
    check("stall_last_b", 32'(m_last), 0);
    step_to(45);
    m_ready = 1'b1;
    step_to(80);
    check_stream("ovf", 16, 0, -1);
    check("ovf_drop_sticky", 32'(drop), 1);
    check("ovf_idle", 32'(busy), 0);

    // Reset in the middle of a capture
    do_reset();
    step_to(10); start_frame(1'b0, 0);
    step_to(12); finish = 1'b1;
    step_to(13);
    check("mid_drop_set", 32'(drop), 1);
    step_to(14);
    check("mid_busy", 32'(busy), 1);
    rst = 1'b0; gen_left = 0;
    step_to(15);
    check("mid_valid", 32'(m_valid), 0);
    check("mid_busy_clr", 32'(busy), 0);
    check("mid_drop_clr", 32'(drop), 0);
    rst = 1'b1;
    rec_data.delete(); rec_last.delete(); rec_cyc.delete();
    step_to(20); start_frame(1'b0, 40);
    step_to(40);
    check_stream("mid", 8, 40, 29);

    // Protocol error: second finish inside a capture
    do_reset();
    step_to(10); start_frame(1'b0, 50);
    step_to(13); finish = 1'b1;
    step_to(14);
    check("proto_drop", 32'(drop), 1);
    step_to(35);
    check_stream("proto", 8, 50, 19);
    check("proto_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
